swc_prio_sched: RTL
===================

SWC_PRIO_SCHED -- requirements
Module: swc_prio_sched

Interface
REQ-001 SHALL provide parameter g_num_prio, default 8, number of priority queues per output port; queue index 7 has the highest priority.
REQ-002 SHALL provide parameter g_page_addr_width, default 10, width of a page address.
REQ-003 SHALL provide parameter g_starve_limit, default 8, number of consecutive contended top-queue grants before a lower queue is forced.
REQ-004 SHALL have port clk_i  input  1  sole clock; all logic is sampled on its rising edge.
REQ-005 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port en_i  input  1  scheduling enable; when low, no new grant is started.
REQ-007 SHALL have port q_nonempty_i  input  g_num_prio  per-queue not-empty flags.
REQ-008 SHALL have port q_head_i  input  g_num_prio*g_page_addr_width  per-queue head page address; queue k occupies bits [(k+1)*W-1 : k*W].
REQ-009 SHALL have port q_pop_o  output  g_num_prio  one-hot, single-cycle pop strobe to the granted queue.
REQ-010 SHALL have port pck_valid_o  output  1  a scheduled packet is offered to the output block.
REQ-011 SHALL have port pck_page_o  output  g_page_addr_width  first page of the offered packet.
REQ-012 SHALL have port pck_prio_o  output  3  queue index of the offered packet.
REQ-013 SHALL have port pck_ack_i  input  1  output block accepts the offered packet.
REQ-014 SHALL have port pck_done_i  input  1  output block has finished transmitting the accepted packet.

Function
REQ-015 SHALL implement the states IDLE, OFFER and BUSY.
REQ-016 IDLE: when en_i=1 and q_nonempty_i is non-zero in cycle N, the block SHALL select a winner and enter OFFER at N+1.
REQ-017 Default selection SHALL be strict priority, choosing the highest-index non-empty queue (the "top" queue).
REQ-018 Contention SHALL mean that at least two bits of q_nonempty_i are set in the decision cycle.
REQ-019 Starvation counter: the counter SHALL increment on each contended grant to the top queue and SHALL clear on an uncontended grant or a forced grant; it saturates at g_starve_limit.
REQ-020 When the counter equals g_starve_limit at a contended decision, the winner SHALL be the highest non-empty queue below the top queue, and the counter SHALL clear.
REQ-021 The decision SHALL register pck_page_o from the winner's q_head_i and pck_prio_o from the winner's index; both SHALL be stable while pck_valid_o=1.
REQ-022 In cycle N+1, q_pop_o SHALL be the winner's one-hot bit for exactly one cycle and pck_valid_o SHALL go high.
REQ-023 OFFER: pck_valid_o SHALL remain high until pck_ack_i=1 is sampled; in the next cycle pck_valid_o=0 and the state is BUSY.
REQ-024 BUSY: on pck_done_i=1 the state SHALL become IDLE; the earliest next grant is in the following cycle.
REQ-025 pck_done_i SHALL be ignored outside BUSY; pck_ack_i SHALL be ignored outside OFFER.
REQ-026 en_i=0 SHALL NOT abort an OFFER or BUSY in progress; it only blocks the IDLE->OFFER transition.
REQ-027 q_pop_o SHALL never have more than one bit set and SHALL never pulse outside the decision-to-OFFER cycle.
REQ-028 Changes to q_nonempty_i during OFFER or BUSY SHALL NOT affect the packet already offered.

Reset
REQ-029 While rst_i=1 at a clock edge, the state SHALL become IDLE and the starvation counter SHALL be 0.
REQ-030 While rst_i=1 at a clock edge, the outputs SHALL be q_pop_o=0, pck_valid_o=0, pck_page_o=0 and pck_prio_o=0.
REQ-031 Reset asserted in OFFER or BUSY SHALL abandon the packet without a further pop; after reset release, scheduling resumes from IDLE.

Verification
REQ-032 q_nonempty_i=8'h06, heads q1=0x011 and q2=0x022, en_i=1 -> one cycle later q_pop_o=8'h04, pck_valid_o=1, pck_page_o=0x022, pck_prio_o=2.
REQ-033 pck_ack_i held low for 5 cycles, then pulsed -> pck_valid_o high for 6 cycles with page and prio constant; no second pop; pck_done_i while in OFFER is ignored.
REQ-034 q_nonempty_i=8'h81 held, ack and done given immediately -> 8 grants to prio 7, 9th grant to prio 0, then the pattern repeats.
REQ-035 en_i=0 with q_nonempty_i=8'hFF for 10 cycles -> q_pop_o=0 and pck_valid_o=0 throughout; en_i=1 -> grant to prio 7 on the next cycle.
REQ-036 rst_i=1 for one cycle while in BUSY -> all outputs 0 and the state is IDLE; the next grant proceeds normally without waiting for pck_done_i.

Source files
------------

// File: rtl/swc_prio_sched.sv
// Output-port packet scheduler: strict priority across g_num_prio queues with a
// starvation guard that periodically forces a grant to the next queue below the top one.
module swc_prio_sched #(
  parameter int g_num_prio        = 8,
  parameter int g_page_addr_width = 10,
  parameter int g_starve_limit    = 8
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      en_i,
  input  logic [g_num_prio-1:0]                     q_nonempty_i,
  input  logic [g_num_prio*g_page_addr_width-1:0]   q_head_i,
  output logic [g_num_prio-1:0]                     q_pop_o,
  output logic                                      pck_valid_o,
  output logic [g_page_addr_width-1:0]              pck_page_o,
  output logic [2:0]                                pck_prio_o,
  input  logic                                      pck_ack_i,
  input  logic                                      pck_done_i
);

  localparam int              CW    = $clog2(g_starve_limit + 1);
  localparam logic [CW-1:0]   LIMIT = CW'(g_starve_limit);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_OFFER = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  logic [1:0]            state;
  logic [CW-1:0]         starve_cnt;

  logic [2:0]            top_idx;
  logic [2:0]            below_idx;
  logic                  contended;
  logic                  any_seen;
  logic                  force_lower;
  logic [2:0]            win_idx;
  logic [g_num_prio-1:0] win_onehot;

  // Ascending scan: each newly found queue demotes the previous top to "below",
  // so after the loop below_idx is the second-highest non-empty queue.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    top_idx   = '0;
    below_idx = '0;
    contended = 1'b0;
    any_seen  = 1'b0;
    for (int k = 0; k < g_num_prio; k++) begin
      if (q_nonempty_i[k]) begin
        if (any_seen) begin
          contended = 1'b1;
          below_idx = top_idx;
        end
        top_idx  = 3'(k);
        any_seen = 1'b1;
      end
    end
    force_lower = contended && (starve_cnt == LIMIT);
    win_idx     = force_lower ? below_idx : top_idx;
    win_onehot          = '0;
    win_onehot[win_idx] = 1'b1;
  end

  // NOTE: synchronous reset; all state here is flops, so every register is cleared.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      starve_cnt  <= '0;
      q_pop_o     <= '0;
      pck_valid_o <= 1'b0;
      pck_page_o  <= '0;
      pck_prio_o  <= '0;
    end else begin
      q_pop_o <= '0;
      case (state)
        S_IDLE: begin
          if (en_i && (|q_nonempty_i)) begin
            state       <= S_OFFER;
            q_pop_o     <= win_onehot;
            pck_valid_o <= 1'b1;
            pck_page_o  <= q_head_i[win_idx*g_page_addr_width +: g_page_addr_width];
            pck_prio_o  <= win_idx;
            if (force_lower || !contended)
              starve_cnt <= '0;
            else if (starve_cnt != LIMIT)
              starve_cnt <= starve_cnt + 1'b1;
          end
        end
        S_OFFER: begin
          if (pck_ack_i) begin
            pck_valid_o <= 1'b0;
            state       <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (pck_done_i)
            state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
